// File: rtl/fp_mul_pkg.sv
// Shared types, constants and result packing for the sequenced FP multiplier.
package fp_mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_NORM = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int unsigned EXP_BIAS = 127;
  localparam int unsigned EXP_INF  = 255;
  localparam int unsigned SIG_W    = 24;
  localparam int unsigned PROD_W   = 48;
  localparam int unsigned EXP_W    = 10;
  localparam int unsigned WORD_W   = 32;

  typedef struct packed {
    logic [WORD_W-1:0] z;
    logic              ovf;
    logic              unf;
  } result_t;

  // Signed infinity word; also used for NaN and inf*0 operands.
  function automatic logic [WORD_W-1:0] inf_word(input logic sign);
    return {sign, 8'hFF, 23'h0};
  endfunction

  // Signed zero word.
  function automatic logic [WORD_W-1:0] zero_word(input logic sign);
    return {sign, 31'h0};
  endfunction

  // Pack a normalised product (hidden bit at P[46]) with overflow/underflow clamping.
  function automatic result_t pack_result(input logic                    sign,
                                          input logic signed [EXP_W-1:0] e,
                                          input logic [PROD_W-1:0]       p);
    result_t r;
    r.z   = zero_word(sign);
    r.ovf = 1'b0;
    r.unf = 1'b0;
    if (e >= $signed(EXP_W'(EXP_INF))) begin
      r.z   = inf_word(sign);
      r.ovf = 1'b1;
    end else if (e <= $signed(EXP_W'(0))) begin
      r.z   = zero_word(sign);
      r.unf = 1'b1;
    end else begin
      r.z = {sign, e[7:0], p[45:23]};
    end
    return r;
  endfunction

endpackage

// File: rtl/fp_mul_norm_step.sv
// One renormalisation action on the product: shift right, shift left, or finish.
module fp_mul_norm_step
  import fp_mul_pkg::*;
(
  input  logic [PROD_W-1:0]        p,
  input  logic signed [EXP_W-1:0]  e,
  output logic [PROD_W-1:0]        p_next_c,
  output logic signed [EXP_W-1:0]  e_next_c,
  output logic                     done_c,
  output logic                     is_zero_c
);

  // Priority: zero product, carry-out bit, already normalised, else shift up.
  always_comb begin
    p_next_c  = p;
    e_next_c  = e;
    done_c    = 1'b0;
    is_zero_c = 1'b0;
    if (p == '0) begin
      is_zero_c = 1'b1;
    end else if (p[47]) begin
      p_next_c = p >> 1;
      e_next_c = e + EXP_W'(1);
    end else if (p[46]) begin
      done_c = 1'b1;
    end else begin
      p_next_c = p << 1;
      e_next_c = e - EXP_W'(1);
    end
  end

endmodule

// File: rtl/fp_mul_sequencer.sv
// Multi-cycle IEEE single multiply: shift-add significand loop, bounded renormalise, truncating pack.
module fp_mul_sequencer
  import fp_mul_pkg::*;
#(
  parameter int unsigned ITER_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_z,
  output logic        out_ovf,
  output logic        out_unf
);

  localparam int unsigned MUL_CYCLES = SIG_W / ITER_BITS;
  localparam int unsigned CNT_W      = 5;

  state_t state;
  state_t state_next;

  // Datapath registers
  logic                     sign;
  logic signed [EXP_W-1:0]  e;
  logic [PROD_W-1:0]        p;
  logic [PROD_W-1:0]        ma;
  logic [SIG_W-1:0]         mb;
  logic [CNT_W-1:0]         cnt;

  // Next values of the registered outputs
  logic        in_ready_next;
  logic        out_valid_next;
  logic [31:0] z_next;
  logic        ovf_next;
  logic        unf_next;

  // Operand decode
  logic [7:0]  ea;
  logic [7:0]  eb;
  logic [22:0] fa;
  logic [22:0] fb;
  logic        a_inf;
  logic        b_inf;
  logic        a_zero;
  logic        b_zero;
  logic        sign_in;
  logic [SIG_W-1:0]        sig_a;
  logic [SIG_W-1:0]        sig_b;
  logic [7:0]              ea_eff;
  logic [7:0]              eb_eff;
  logic signed [EXP_W-1:0] e_init;

  // Loop helpers
  logic                     mul_last;
  logic [ITER_BITS-1:0]     chunk;
  logic [PROD_W-1:0]        partial;
  logic [PROD_W-1:0]        norm_p;
  logic signed [EXP_W-1:0]  norm_e;
  logic                     norm_done;
  logic                     norm_zero;
  result_t                  packed_r;

  assign ea      = in_a[30:23];
  assign eb      = in_b[30:23];
  assign fa      = in_a[22:0];
  assign fb      = in_b[22:0];
  assign a_inf   = (ea == 8'hFF);
  assign b_inf   = (eb == 8'hFF);
  assign a_zero  = (ea == 8'h00) && (fa == 23'h0);
  assign b_zero  = (eb == 8'h00) && (fb == 23'h0);
  assign sign_in = in_a[31] ^ in_b[31];

  // Denormals carry no hidden bit and use exponent 1
  assign sig_a  = {(ea != 8'h00), fa};
  assign sig_b  = {(eb != 8'h00), fb};
  assign ea_eff = (ea == 8'h00) ? 8'd1 : ea;
  assign eb_eff = (eb == 8'h00) ? 8'd1 : eb;
  assign e_init = EXP_W'(ea_eff) + EXP_W'(eb_eff) - EXP_W'(EXP_BIAS);

  assign mul_last = (cnt == CNT_W'(MUL_CYCLES - 1));
  assign chunk    = mb[ITER_BITS-1:0];
  assign partial  = ma * PROD_W'(chunk);
  assign packed_r = pack_result(sign, e, p);

  fp_mul_norm_step u_norm (
    .p         (p),
    .e         (e),
    .p_next_c  (norm_p),
    .e_next_c  (norm_e),
    .done_c    (norm_done),
    .is_zero_c (norm_zero)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          if (a_inf || b_inf || a_zero || b_zero) state_next = ST_DONE;
          else                                    state_next = ST_MUL;
        end
      end
      ST_MUL:  if (mul_last) state_next = ST_NORM;
      ST_NORM: if (norm_done || norm_zero) state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output logic: next values for the registered handshake and result outputs
  always_comb begin
    in_ready_next  = (state_next == ST_IDLE);
    out_valid_next = (state_next == ST_DONE);
    z_next         = out_z;
    ovf_next       = out_ovf;
    unf_next       = out_unf;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          ovf_next = 1'b0;
          unf_next = 1'b0;
          if (a_inf || b_inf)        z_next = inf_word(sign_in);
          else if (a_zero || b_zero) z_next = zero_word(sign_in);
        end
      end
      ST_NORM: begin
        if (norm_zero) begin
          z_next   = zero_word(sign);
          unf_next = 1'b1;
        end else if (norm_done) begin
          z_next   = packed_r.z;
          ovf_next = packed_r.ovf;
          unf_next = packed_r.unf;
        end
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_z     <= '0;
      out_ovf   <= 1'b0;
      out_unf   <= 1'b0;
    end else begin
      in_ready  <= in_ready_next;
      out_valid <= out_valid_next;
      out_z     <= z_next;
      out_ovf   <= ovf_next;
      out_unf   <= unf_next;
    end
  end

  // Datapath: operand latch, shift-add multiply, renormalise
  always_ff @(posedge clk) begin
    if (rst) begin
      sign <= 1'b0;
      e    <= '0;
      p    <= '0;
      ma   <= '0;
      mb   <= '0;
      cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            sign <= sign_in;
            e    <= e_init;
            p    <= '0;
            ma   <= PROD_W'(sig_a);
            mb   <= sig_b;
            cnt  <= '0;
          end
        end
        ST_MUL: begin
          p   <= p + partial;
          ma  <= ma << ITER_BITS;
          mb  <= mb >> ITER_BITS;
          cnt <= cnt + CNT_W'(1);
        end
        ST_NORM: begin
          p <= norm_p;
          e <= norm_e;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_sequencer.sv
// Scoreboard bench for fp_mul_sequencer at ITER_BITS=1 and ITER_BITS=8.
module tb_fp_mul_sequencer;

  typedef struct {
    logic [31:0] z;
    logic        ovf;
    logic        unf;
    int          lat;
    int          t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic        sel;
  logic [31:0] in_a;
  logic [31:0] in_b;

  logic        in_ready1, out_valid1, ovf1, unf1;
  logic [31:0] z1;
  logic        in_ready8, out_valid8, ovf8, unf8;
  logic [31:0] z8;

  logic        in_ready, out_valid, out_ovf, out_unf;
  logic [31:0] out_z;

  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  fp_mul_sequencer #(.ITER_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid1), .out_ready(out_ready & ~sel),
    .out_z(z1), .out_ovf(ovf1), .out_unf(unf1)
  );

  fp_mul_sequencer #(.ITER_BITS(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_ready(in_ready8),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid8), .out_ready(out_ready & sel),
    .out_z(z8), .out_ovf(ovf8), .out_unf(unf8)
  );

  assign in_ready  = sel ? in_ready8  : in_ready1;
  assign out_valid = sel ? out_valid8 : out_valid1;
  assign out_z     = sel ? z8         : z1;
  assign out_ovf   = sel ? ovf8       : ovf1;
  assign out_unf   = sel ? unf8       : unf1;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Wait for in_ready, present one operand pair for a single cycle, record the expectation.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] z,
                       input logic ovf, input logic unf, input int lat);
    exp_t x;
    int   n;
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL issue_ready: in_ready=%b required 1", in_ready);
    end
    in_a = a; in_b = b; in_valid = 1'b1;
    x.z = z; x.ovf = ovf; x.unf = unf; x.lat = lat; x.t = cyc;
    sb.push_back(x);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait for out_valid, compare against the oldest expectation, then handshake.
  task automatic collect(input string name);
    exp_t x;
    int   n;
    if (sb.size() == 0) begin
      checks++; fails++;
      $display("FAIL %s_sb: scoreboard empty", name);
      return;
    end
    x = sb.pop_front();
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s_timeout: out_valid=%b required 1", name, out_valid);
    end
    checks++;
    if (cyc - x.t !== x.lat) begin
      fails++;
      $display("FAIL %s_latency: got t+%0d required t+%0d", name, cyc - x.t, x.lat);
    end
    checks++;
    if (out_z !== x.z) begin
      fails++;
      $display("FAIL %s_z: got %h required %h", name, out_z, x.z);
    end
    checks++;
    if ({out_ovf, out_unf} !== {x.ovf, x.unf}) begin
      fails++;
      $display("FAIL %s_flags: ovf/unf got %b%b required %b%b", name, out_ovf, out_unf, x.ovf, x.unf);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s_release: out_valid=%b in_ready=%b required 0 1", name, out_valid, in_ready);
    end
  endtask

  task automatic op(input string name, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] z, input logic ovf, input logic unf, input int lat);
    issue(a, b, z, ovf, unf, lat);
    collect(name);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        fails++;
        $display("FAIL reset_hs[%0d]: in_ready=%b out_valid=%b required 1 0", s, in_ready, out_valid);
      end
      checks++;
      if (out_z !== 32'h0 || out_ovf !== 1'b0 || out_unf !== 1'b0) begin
        fails++;
        $display("FAIL reset_out[%0d]: z=%h ovf=%b unf=%b required 0 0 0", s, out_z, out_ovf, out_unf);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_normal();
    op("mul_2x3",      32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0, 26);
    op("mul_neg",      32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0, 1'b0, 26);
    op("mul_carry",    32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 1'b0, 27);
    op("mul_denorm",   32'h00400000, 32'h4B000000, 32'h0B800000, 1'b0, 1'b0, 27);
  endtask

  task automatic test_boundary();
    op("ovf",          32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0, 26);
    op("unf",          32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1, 26);
    // Tiny denormal product needs 46 left shifts plus the pack cycle
    op("norm_47",      32'h80000001, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 72);
    op("flags_clear",  32'h40000000, 32'h40000000, 32'h40800000, 1'b0, 1'b0, 26);
  endtask

  task automatic test_special();
    op("zero",         32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, 1'b0, 1);
    op("inf_x_zero",   32'h7F800000, 32'h00000000, 32'h7F800000, 1'b0, 1'b0, 1);
    op("nan",          32'h3F800000, 32'hFFC00001, 32'hFF800000, 1'b0, 1'b0, 1);
  endtask

  task automatic test_hold();
    exp_t x;
    int   n;
    logic [31:0] z0;
    issue(32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0, 26);
    x = sb.pop_front();
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (out_valid !== 1'b1 || out_z !== x.z) begin
      fails++;
      $display("FAIL hold_first: out_valid=%b z=%h required 1 %h", out_valid, out_z, x.z);
    end
    z0 = x.z;
    in_a = 32'h40000000; in_b = 32'h40000000; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_z !== z0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL hold_cycle%0d: z=%h valid=%b in_ready=%b required %h 1 0", i, out_z, out_valid, in_ready, z0);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL hold_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    x.z = 32'h40800000; x.ovf = 1'b0; x.unf = 1'b0; x.lat = 26; x.t = cyc;
    sb.push_back(x);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL hold_accept: in_ready=%b required 0", in_ready);
    end
    collect("hold_next");
  endtask

  task automatic test_reset_mid();
    int t;
    issue(32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0, 26);
    t = sb[sb.size()-1].t;
    void'(sb.pop_back());
    while (cyc < t + 10) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_z !== 32'h0) begin
      fails++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b z=%h required 1 0 0", in_ready, out_valid, out_z);
    end
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_discard: out_valid=%b required 0", out_valid);
    end
    op("after_reset",  32'h40000000, 32'h40000000, 32'h40800000, 1'b0, 1'b0, 26);
  endtask

  task automatic test_iter8();
    sel = 1'b1;
    #0;
    op("i8_2x3",       32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0, 5);
    op("i8_carry",     32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 1'b0, 6);
    op("i8_norm_47",   32'h00000001, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 51);
    op("i8_special",   32'h00000000, 32'hC0000000, 32'h80000000, 1'b0, 1'b0, 1);
    sel = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0;
    in_a = '0; in_b = '0;
    test_reset();
    test_normal();
    test_boundary();
    test_special();
    test_hold();
    test_reset_mid();
    test_iter8();
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
